// File: rtl/nvram_xfer_if.sv
// Bundle of the CPU port, host requests, load/save byte streams, NVRAM port and status
// for nvram_xfer. The slave side is the transfer block; the master side is its surroundings.
interface nvram_xfer_if;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_din;
    logic       req_load;
    logic       req_save;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       sv_valid;
    logic [7:0] sv_data;
    logic       sv_ready;
    logic       nv_we;
    logic [7:0] nv_addr;
    logic [7:0] nv_din;
    logic [7:0] nv_dout;
    logic       busy;
    logic       done;

    modport master (
        output cpu_we, cpu_addr, cpu_din, req_load, req_save,
        output ld_valid, ld_data, sv_ready, nv_dout,
        input  ld_ready, sv_valid, sv_data, nv_we, nv_addr, nv_din, busy, done
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_din, req_load, req_save,
        input  ld_valid, ld_data, sv_ready, nv_dout,
        output ld_ready, sv_valid, sv_data, nv_we, nv_addr, nv_din, busy, done
    );
endinterface

// File: rtl/nvram_xfer.sv
// Moves the whole NVRAM (addresses 0..LAST_ADDR) in from a load byte stream or out to a
// save byte stream; while idle the CPU owns the NVRAM port through a combinational bypass.
module nvram_xfer #(
    parameter logic [7:0] LAST_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    nvram_xfer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SAVE_RD,
        SAVE_OUT,
        FIN
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [7:0] cnt_reg;
    logic [7:0] cnt_next;

    logic       nv_we_next;
    logic [7:0] nv_addr_next;
    logic [7:0] nv_din_next;
    logic       ld_ready_next;
    logic       sv_valid_next;
    logic [7:0] sv_data_next;
    logic       busy_next;
    logic       done_next;

    logic       cnt_last;

    assign cnt_last = (cnt_reg == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        nv_we_next    = 1'b0;
        nv_addr_next  = cnt_reg;
        nv_din_next   = 8'h00;
        ld_ready_next = 1'b0;
        sv_valid_next = 1'b0;
        sv_data_next  = 8'h00;
        busy_next     = 1'b1;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next    = 1'b0;
                nv_we_next   = bus.cpu_we;
                nv_addr_next = bus.cpu_addr;
                nv_din_next  = bus.cpu_din;
                // Load takes priority when both requests arrive together.
                if (bus.req_load) begin
                    cnt_next   = 8'h00;
                    state_next = LOAD;
                end else if (bus.req_save) begin
                    cnt_next   = 8'h00;
                    state_next = SAVE_RD;
                end
            end

            LOAD: begin
                ld_ready_next = 1'b1;
                nv_din_next   = bus.ld_data;
                nv_we_next    = bus.ld_valid;
                if (bus.ld_valid) begin
                    if (cnt_last) begin
                        state_next = FIN;
                    end else begin
                        cnt_next = cnt_reg + 8'h01;
                    end
                end
            end

            SAVE_RD: begin
                // Address is presented here; the RAM returns data on the next clock.
                state_next = SAVE_OUT;
            end

            SAVE_OUT: begin
                sv_valid_next = 1'b1;
                sv_data_next  = bus.nv_dout;
                if (bus.sv_ready) begin
                    if (cnt_last) begin
                        state_next = FIN;
                    end else begin
                        cnt_next   = cnt_reg + 8'h01;
                        state_next = SAVE_RD;
                    end
                end
            end

            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.nv_we    = nv_we_next;
    assign bus.nv_addr  = nv_addr_next;
    assign bus.nv_din   = nv_din_next;
    assign bus.ld_ready = ld_ready_next;
    assign bus.sv_valid = sv_valid_next;
    assign bus.sv_data  = sv_data_next;
    assign bus.busy     = busy_next;
    assign bus.done     = done_next;

endmodule

// File: tb/tb_nvram_xfer.sv
// Scoreboard bench for nvram_xfer: a full-size instance and a LAST_ADDR=0x0F instance,
// each with its own 256x8 registered-read RAM model and monitor process.
module tb_nvram_xfer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nvram_xfer_if b0();
    nvram_xfer_if b1();

    nvram_xfer u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    nvram_xfer #(.LAST_ADDR(8'h0F)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic        fill0_go = 1'b0;
    logic        fill1_go = 1'b0;
    logic [7:0]  fill0_val = 8'h00;
    logic        fill0_inv = 1'b0;

    logic [7:0]  exp_sv0[$];
    logic [15:0] exp_wr0[$];
    logic [7:0]  exp_sv1[$];
    logic [15:0] exp_wr1[$];
    int          done_cnt0 = 0;
    int          done_cnt1 = 0;

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // RAM models; the fill strobes preload contents for a test.
    always @(posedge clk) begin
        if (fill0_go) begin
            for (int k = 0; k < 256; k++) mem0[k] <= fill0_inv ? ~k[7:0] : fill0_val;
        end else if (b0.nv_we) begin
            mem0[b0.nv_addr] <= b0.nv_din;
        end
        b0.nv_dout <= mem0[b0.nv_addr];
    end

    always @(posedge clk) begin
        if (fill1_go) begin
            for (int k = 0; k < 256; k++) mem1[k] <= ~k[7:0];
        end else if (b1.nv_we) begin
            mem1[b1.nv_addr] <= b1.nv_din;
        end
        b1.nv_dout <= mem1[b1.nv_addr];
    end

    // Monitor for u0
    logic       stall0 = 1'b0;
    logic [7:0] held0 = 8'h00;
    always @(negedge clk) begin
        if (b0.sv_valid) begin
            cmp("sv0_expected", 16'(exp_sv0.size() != 0), 16'd1);
            if (b0.sv_ready && exp_sv0.size() != 0)
                cmp("sv0_data", {8'h00, b0.sv_data}, {8'h00, exp_sv0.pop_front()});
            if (stall0) cmp("sv0_stable", {8'h00, b0.sv_data}, {8'h00, held0});
        end else begin
            cmp("sv0_zero", {8'h00, b0.sv_data}, 16'h0000);
        end
        stall0 = b0.sv_valid && !b0.sv_ready;
        held0  = b0.sv_data;
        if (b0.nv_we && (b0.busy || !b0.cpu_we)) begin
            cmp("wr0_expected", 16'(exp_wr0.size() != 0), 16'd1);
            if (exp_wr0.size() != 0)
                cmp("wr0_addr_data", {b0.nv_addr, b0.nv_din}, exp_wr0.pop_front());
        end
        if (b0.done) done_cnt0++;
    end

    // Monitor for u1
    always @(negedge clk) begin
        if (b1.sv_valid) begin
            cmp("sv1_expected", 16'(exp_sv1.size() != 0), 16'd1);
            if (b1.sv_ready && exp_sv1.size() != 0)
                cmp("sv1_data", {8'h00, b1.sv_data}, {8'h00, exp_sv1.pop_front()});
        end
        if (b1.nv_we && (b1.busy || !b1.cpu_we)) begin
            cmp("wr1_expected", 16'(exp_wr1.size() != 0), 16'd1);
            if (exp_wr1.size() != 0)
                cmp("wr1_addr_data", {b1.nv_addr, b1.nv_din}, exp_wr1.pop_front());
        end
        if (b1.done) done_cnt1++;
    end

    // Streams n load bytes into u0; gap>0 drops ld_valid one cycle in every gap.
    task automatic load0(input int n, input logic [7:0] key, input int gap, output int cycles);
        int k = 0;
        int it = 0;
        logic rdy;
        while (k < n && it < 5000) begin
            b0.ld_valid = (gap == 0) ? 1'b1 : ((it % gap) != gap - 1);
            b0.ld_data  = k[7:0] ^ key;
            rdy = b0.ld_ready;
            @(posedge clk);
            if (b0.ld_valid && rdy) k++;
            it++;
            #1;
        end
        cmp("load0_bytes", 16'(k), 16'(n));
        cycles = it;
    endtask

    task automatic load1(input int n, input logic [7:0] key, input int gap);
        int k = 0;
        int it = 0;
        logic rdy;
        while (k < n && it < 1000) begin
            b1.ld_valid = (it % gap) != gap - 1;
            b1.ld_data  = k[7:0] ^ key;
            rdy = b1.ld_ready;
            @(posedge clk);
            if (b1.ld_valid && rdy) k++;
            it++;
            #1;
        end
        cmp("load1_bytes", 16'(k), 16'(n));
    endtask

    task automatic fill0(input logic inv, input logic [7:0] val);
        fill0_inv = inv;
        fill0_val = val;
        fill0_go  = 1'b1;
        @(posedge clk);
        #1;
        fill0_go = 1'b0;
    endtask

    task automatic idle_bus(input int which);
        if (which == 0) begin
            b0.cpu_we = 0; b0.cpu_addr = 0; b0.cpu_din = 0; b0.req_load = 0; b0.req_save = 0;
            b0.ld_valid = 0; b0.ld_data = 0; b0.sv_ready = 0;
        end else begin
            b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_din = 0; b1.req_load = 0; b1.req_save = 0;
            b1.ld_valid = 0; b1.ld_data = 0; b1.sv_ready = 0;
        end
    endtask

    initial begin
        int cyc;
        int d0;
        int it;
        idle_bus(0);
        idle_bus(1);

        // Reset state and CPU pass-through while held in reset
        b0.cpu_we = 1; b0.cpu_addr = 8'h33; b0.cpu_din = 8'h44;
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_busy", {15'h0, b0.busy}, 16'h0);
        cmp("rst_done", {15'h0, b0.done}, 16'h0);
        cmp("rst_ld_ready", {15'h0, b0.ld_ready}, 16'h0);
        cmp("rst_sv_valid", {15'h0, b0.sv_valid}, 16'h0);
        cmp("rst_nv_we", {15'h0, b0.nv_we}, 16'h1);
        cmp("rst_nv_addr_din", {b0.nv_addr, b0.nv_din}, 16'h3344);
        repeat (2) @(posedge clk);
        #1;
        idle_bus(0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("post_rst_busy", {15'h0, b0.busy}, 16'h0);
        $display("reset released at %0t", $time);

        // Full load, continuous valid: one byte per clock
        for (int k = 0; k < 256; k++) exp_wr0.push_back({k[7:0], k[7:0] ^ 8'h5A});
        d0 = done_cnt0;
        b0.req_load = 1;
        @(posedge clk);
        #1;
        b0.req_load = 0;
        cmp("load_ld_ready", {15'h0, b0.ld_ready}, 16'h1);
        load0(256, 8'h5A, 0, cyc);
        b0.ld_valid = 0;
        cmp("load_cycles", 16'(cyc), 16'd256);
        cmp("load_done_pulse", {15'h0, b0.done}, 16'h1);
        @(posedge clk);
        #1;
        cmp("load_done_once", {15'h0, b0.done}, 16'h0);
        cmp("load_busy_clear", {15'h0, b0.busy}, 16'h0);
        cmp("load_done_cnt", 16'(done_cnt0 - d0), 16'd1);
        cmp("load_wr_left", 16'(exp_wr0.size()), 16'd0);
        for (int k = 0; k < 256; k++) cmp("load_mem", {8'h00, mem0[k]}, {8'h00, k[7:0] ^ 8'h5A});
        $display("load of 256 bytes finished in %0d cycles", cyc);

        // CPU write while idle lands on the same edge
        b0.cpu_we = 1; b0.cpu_addr = 8'h10; b0.cpu_din = 8'hAA;
        @(posedge clk);
        #1;
        b0.cpu_we = 0;
        cmp("cpu_wr_idle", {8'h00, mem0[8'h10]}, 16'h00AA);
        $display("idle CPU write addr 10 data AA");

        // Save with irregular backpressure and a dropped CPU write
        fill0(1'b1, 8'h00);
        for (int k = 0; k < 256; k++) exp_sv0.push_back(~k[7:0]);
        d0 = done_cnt0;
        b0.req_save = 1;
        @(posedge clk);
        #1;
        b0.req_save = 0;
        it = 0;
        while (done_cnt0 == d0 && it < 3000) begin
            b0.sv_ready = (it % 3) == 0;
            b0.cpu_we   = (it == 20);
            b0.cpu_addr = 8'h10;
            b0.cpu_din  = 8'hAA;
            @(posedge clk);
            #1;
            it++;
        end
        b0.cpu_we = 0;
        b0.sv_ready = 0;
        cmp("save_done_cnt", 16'(done_cnt0 - d0), 16'd1);
        cmp("save_sv_left", 16'(exp_sv0.size()), 16'd0);
        cmp("save_cpu_dropped", {8'h00, mem0[8'h10]}, 16'h00EF);
        $display("save of 256 bytes finished in %0d cycles", it);

        // Both requests together: load wins; then load with ld_valid gaps
        for (int k = 0; k < 256; k++) exp_wr0.push_back({k[7:0], k[7:0] ^ 8'hC3});
        d0 = done_cnt0;
        b0.req_load = 1; b0.req_save = 1; b0.sv_ready = 1;
        @(posedge clk);
        #1;
        b0.req_load = 0; b0.req_save = 0;
        cmp("both_ld_ready", {15'h0, b0.ld_ready}, 16'h1);
        cmp("both_sv_valid", {15'h0, b0.sv_valid}, 16'h0);
        cmp("both_busy", {15'h0, b0.busy}, 16'h1);
        load0(256, 8'hC3, 3, cyc);
        b0.ld_valid = 0;
        b0.sv_ready = 0;
        @(posedge clk);
        #1;
        cmp("gap_done_cnt", 16'(done_cnt0 - d0), 16'd1);
        cmp("gap_wr_left", 16'(exp_wr0.size()), 16'd0);
        for (int k = 0; k < 256; k++) cmp("gap_mem", {8'h00, mem0[k]}, {8'h00, k[7:0] ^ 8'hC3});
        $display("gapped load of 256 bytes finished in %0d cycles", cyc);

        // Reset after 100 load bytes aborts at once
        fill0(1'b0, 8'h11);
        for (int k = 0; k < 100; k++) exp_wr0.push_back({k[7:0], k[7:0] ^ 8'h5A});
        b0.req_load = 1;
        @(posedge clk);
        #1;
        b0.req_load = 0;
        load0(100, 8'h5A, 0, cyc);
        rst_n = 1'b0;
        #1;
        cmp("abort_busy", {15'h0, b0.busy}, 16'h0);
        cmp("abort_ld_ready", {15'h0, b0.ld_ready}, 16'h0);
        cmp("abort_nv_we", {15'h0, b0.nv_we}, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        b0.ld_valid = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cmp("abort_idle", {15'h0, b0.busy}, 16'h0);
        cmp("abort_wr_left", 16'(exp_wr0.size()), 16'd0);
        for (int k = 0; k < 256; k++)
            cmp("abort_mem", {8'h00, mem0[k]}, {8'h00, (k < 100) ? (k[7:0] ^ 8'h5A) : 8'h11});
        $display("load aborted by reset after 100 bytes");

        // Short instance: gapped load then save of exactly 16 bytes
        fill1_go = 1'b1;
        @(posedge clk);
        #1;
        fill1_go = 1'b0;
        for (int k = 0; k < 16; k++) exp_wr1.push_back({k[7:0], k[7:0] ^ 8'hA5});
        d0 = done_cnt1;
        b1.req_load = 1;
        @(posedge clk);
        #1;
        b1.req_load = 0;
        load1(16, 8'hA5, 2);
        b1.ld_valid = 0;
        @(posedge clk);
        #1;
        cmp("s_load_done_cnt", 16'(done_cnt1 - d0), 16'd1);
        cmp("s_load_wr_left", 16'(exp_wr1.size()), 16'd0);
        for (int k = 0; k < 16; k++) cmp("s_load_mem", {8'h00, mem1[k]}, {8'h00, k[7:0] ^ 8'hA5});
        cmp("s_load_mem16", {8'h00, mem1[16]}, 16'h00EF);
        $display("short load of 16 bytes finished");

        for (int k = 0; k < 16; k++) exp_sv1.push_back(k[7:0] ^ 8'hA5);
        d0 = done_cnt1;
        b1.req_save = 1; b1.sv_ready = 1;
        @(posedge clk);
        #1;
        b1.req_save = 0;
        it = 0;
        while (done_cnt1 == d0 && it < 200) begin
            @(posedge clk);
            #1;
            it++;
        end
        repeat (4) @(posedge clk);
        #1;
        b1.sv_ready = 0;
        cmp("s_save_done_cnt", 16'(done_cnt1 - d0), 16'd1);
        cmp("s_save_sv_left", 16'(exp_sv1.size()), 16'd0);
        cmp("s_save_busy", {15'h0, b1.busy}, 16'h0);
        $display("short save of 16 bytes finished in %0d cycles", it);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
